// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared constants, state encoding and address helper for the SPI flash reader
package spi_flash_pkg;
  localparam int SPI_ADDR_W = 24;
  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD, GAP} spi_rd_state_t;
  function automatic logic [SPI_ADDR_W-1:0] next_word_addr(input logic [SPI_ADDR_W-1:0] a);
    return a + SPI_ADDR_W'(4);
  endfunction
endpackage

// File: rtl/spi_flash_shifter.sv
// spi_flash_shifter: mode-0 bit engine -- clock divider, MSB-first byte shift out, MISO sampling
module spi_flash_shifter #(
  parameter int CLK_DIV = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_more,
  input  logic [7:0] i_tx,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_byte_end,
  output logic       o_byte_done,
  output logic [7:0] o_rx
);
  logic       r_run;
  logic       r_sclk;
  logic       r_mosi;
  logic       r_done;
  logic [3:0] r_div;
  logic [2:0] r_bit;
  logic [6:0] r_tx;
  logic [7:0] r_rx;
  logic       w_tick;
  logic       w_cell_end;
  assign w_tick      = r_run && r_div == 4'(CLK_DIV - 1);
  assign w_cell_end  = w_tick && r_sclk;
  assign o_byte_end  = w_cell_end && r_bit == 3'd7;
  assign o_sclk      = r_sclk;
  assign o_mosi      = r_mosi;
  assign o_byte_done = r_done;
  assign o_rx        = r_rx;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_run  <= 1'b0;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_done <= 1'b0;
      r_div  <= '0;
      r_bit  <= '0;
      r_tx   <= '0;
      r_rx   <= '0;
    end else begin
      r_done <= o_byte_end;
      if (r_run && r_sclk && r_div == '0) r_rx <= {r_rx[6:0], i_miso};
      if (i_start) begin
        r_run  <= 1'b1;
        r_div  <= '0;
        r_sclk <= 1'b0;
        r_bit  <= '0;
        r_mosi <= i_tx[7];
        r_tx   <= i_tx[6:0];
      end else if (r_run) begin
        r_div <= w_tick ? '0 : r_div + 4'd1;
        if (w_tick) r_sclk <= !r_sclk;
        // the end of a bit cell is the first cycle of the next low half, so MOSI moves here
        if (w_cell_end) begin
          r_bit  <= r_bit + 3'd1;
          r_mosi <= r_bit == 3'd7 ? i_tx[7] : r_tx[6];
          r_tx   <= r_bit == 3'd7 ? i_tx[6:0] : {r_tx[5:0], 1'b0};
          if (o_byte_end && !i_more) r_run <= 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: 32-bit word fetch over single-IO READ (0x03) with chip select held for streaming
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV     = 1,
  parameter int HOLD_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);
  spi_rd_state_t   r_state;
  logic            r_csb;
  logic            r_valid;
  logic            r_pend;
  logic [31:0]     r_rdata;
  logic [31:0]     r_acc;
  logic [23:0]     r_tx;
  logic [23:0]     r_next;
  logic [23:0]     r_pend_addr;
  logic [3:0]      r_left;
  logic [15:0]     r_hold;
  logic [5:0]      r_gap;
  logic            w_accept;
  logic            w_gap_end;
  logic            w_cold;
  logic            w_warm;
  logic            w_byte_end;
  logic            w_byte_done;
  logic [7:0]      w_tx;
  logic [7:0]      w_rx;
  logic [23:0]     w_addr;
  assign req_ready   = r_state == IDLE || r_state == HOLD;
  assign w_accept    = req_valid && req_ready;
  assign w_gap_end   = r_state == GAP && r_gap == 6'(2 * CLK_DIV - 1);
  assign w_cold      = (w_accept && r_state == IDLE) || (w_gap_end && r_pend);
  assign w_warm      = w_accept && r_state == HOLD && req_addr == r_next;
  assign w_addr      = r_state == GAP ? r_pend_addr : req_addr;
  assign w_tx        = w_cold ? SPI_CMD_READ : w_warm ? 8'h00 : r_tx[23:16];
  assign rdata_valid = r_valid;
  assign rdata       = r_rdata;
  assign flash_csb   = r_csb;
  spi_flash_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clock      (clock),
    .reset      (reset),
    .i_start    (w_cold || w_warm),
    .i_more     (r_left != 4'd1),
    .i_tx       (w_tx),
    .i_miso     (flash_io1),
    .o_sclk     (flash_clk),
    .o_mosi     (flash_io0),
    .o_byte_end (w_byte_end),
    .o_byte_done(w_byte_done),
    .o_rx       (w_rx)
  );
  // r_left counts bytes still to shift: 8 for a cold fetch (cmd + addr + data), 4 when streaming
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_csb       <= 1'b1;
      r_valid     <= 1'b0;
      r_pend      <= 1'b0;
      r_rdata     <= '0;
      r_acc       <= '0;
      r_tx        <= '0;
      r_next      <= '0;
      r_pend_addr <= '0;
      r_left      <= '0;
      r_hold      <= '0;
      r_gap       <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_byte_end) begin
        r_tx   <= r_tx << 8;
        r_left <= r_left - 4'd1;
      end
      if (w_cold) begin
        r_state <= CMD;
        r_csb   <= 1'b0;
        r_pend  <= 1'b0;
        r_tx    <= w_addr;
        r_left  <= 4'd8;
        r_next  <= next_word_addr(w_addr);
      end else if (w_warm) begin
        r_state <= DATA;
        r_left  <= 4'd4;
        r_next  <= next_word_addr(req_addr);
      end else begin
        case (r_state)
          CMD:  if (w_byte_done) r_state <= ADDR;
          ADDR: if (w_byte_done && r_left == 4'd4) r_state <= DATA;
          DATA: if (w_byte_done) begin
            r_acc <= {w_rx, r_acc[31:8]};
            if (r_left == 4'd0) begin
              r_rdata <= {w_rx, r_acc[31:8]};
              r_valid <= 1'b1;
              r_hold  <= '0;
              r_state <= HOLD_CYCLES == 0 ? IDLE : HOLD;
              r_csb   <= HOLD_CYCLES == 0;
            end
          end
          HOLD: if (w_accept || r_hold == 16'(HOLD_CYCLES - 1)) begin
            r_state     <= GAP;
            r_csb       <= 1'b1;
            r_gap       <= '0;
            r_pend      <= w_accept;
            r_pend_addr <= req_addr;
          end else begin
            r_hold <= r_hold + 16'd1;
          end
          GAP:  if (w_gap_end) r_state <= IDLE;
                else r_gap <= r_gap + 6'd1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: directed checks of cold, streaming, gap, expiry, wrap and reset behaviour
module tb_spi_flash_reader;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, rv0, csb0, fclk0, mosi0;
  logic        miso0 = 1'b0;
  logic [23:0] req_addr;
  logic [31:0] rd0;
  logic        req_valid3, ready3, rv3, csb3, fclk3, mosi3;
  logic        miso3 = 1'b0;
  logic [23:0] req_addr3;
  logic [31:0] rd3;
  int          n_cmp = 0;
  int          n_bad = 0;
  always #5 clock = ~clock;
  spi_flash_reader #(.CLK_DIV(1), .HOLD_CYCLES(32)) dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rdata_valid(rv0), .rdata(rd0), .flash_csb(csb0),
    .flash_clk(fclk0), .flash_io0(mosi0), .flash_io1(miso0)
  );
  spi_flash_reader #(.CLK_DIV(3), .HOLD_CYCLES(32)) dut3 (
    .clock(clock), .reset(reset), .req_valid(req_valid3), .req_ready(ready3),
    .req_addr(req_addr3), .rdata_valid(rv3), .rdata(rd3), .flash_csb(csb3),
    .flash_clk(fclk3), .flash_io0(mosi3), .flash_io1(miso3)
  );
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000000: return 8'h93;
      24'h000001: return 8'h00;
      24'h000002: return 8'h00;
      24'h000003: return 8'h6F;
      default:    return a[7:0] ^ 8'hA5;
    endcase
  endfunction
  // flash responders: shift in 32 cmd/addr bits, then stream bytes from the address on falling edges
  int          cnt0 = 0, cnt3 = 0;
  logic [31:0] sh0 = '0, sh3 = '0;
  logic [7:0]  b0, b3;
  always @(posedge fclk0 or posedge csb0)
    if (csb0) cnt0 = 0;
    else begin
      if (cnt0 < 32) sh0 = {sh0[30:0], mosi0};
      cnt0++;
    end
  always @(negedge fclk0)
    if (!csb0 && cnt0 >= 32) begin
      b0 = flash_byte(sh0[23:0] + 24'(cnt0 / 8 - 4));
      miso0 = b0[~3'(cnt0)];
    end
  always @(posedge fclk3 or posedge csb3)
    if (csb3) cnt3 = 0;
    else begin
      if (cnt3 < 32) sh3 = {sh3[30:0], mosi3};
      cnt3++;
    end
  always @(negedge fclk3)
    if (!csb3 && cnt3 >= 32) begin
      b3 = flash_byte(sh3[23:0] + 24'(cnt3 / 8 - 4));
      miso3 = b3[~3'(cnt3)];
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic issue(input bit k, input logic [23:0] a);
    int w = 0;
    if (k) begin req_valid3 = 1'b1; req_addr3 = a; end
    else begin req_valid = 1'b1; req_addr = a; end
    while (!(k ? ready3 : req_ready) && w < 1000) begin
      tick(1);
      w++;
    end
    check("accept_wait", 32'(w < 1000), 32'd1);
    tick(1);
    req_valid  = 1'b0;
    req_valid3 = 1'b0;
  endtask
  task automatic wait_valid(input bit k, output int c, output int hi);
    c  = 0;
    hi = int'(k ? csb3 : csb0);
    while (!(k ? rv3 : rv0) && c < 1000) begin
      tick(1);
      c++;
      if (!(k ? rv3 : rv0) && (k ? csb3 : csb0)) hi++;
    end
  endtask
  initial begin
    int c, hi, p;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_valid3 = 1'b0; req_addr3 = '0;
    tick(2);
    check("rst_csb", 32'(csb0), 32'd1);
    check("rst_clk", 32'(fclk0), 32'd0);
    check("rst_io0", 32'(mosi0), 32'd0);
    check("rst_valid", 32'(rv0), 32'd0);
    check("rst_rdata", rd0, 32'h0);
    check("rst_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    tick(3);
    issue(0, 24'h000000);
    check("cold_csb_fall", 32'(csb0), 32'd0);
    check("cold_io0_bit7", 32'(mosi0), 32'd0);
    check("cold_ready_low", 32'(req_ready), 32'd0);
    wait_valid(0, c, hi);
    check("cold_latency", c, 32'd129);
    check("cold_csb_low", hi, 32'd0);
    check("cold_rdata", rd0, 32'h6F000093);
    check("cold_mosi_stream", sh0, 32'h03000000);
    tick(1);
    check("valid_pulse", 32'(rv0), 32'd0);
    check("rdata_stable", rd0, 32'h6F000093);
    issue(0, 24'h000004);
    wait_valid(0, c, hi);
    check("stream4_latency", c, 32'd65);
    check("stream4_csb_low", hi, 32'd0);
    check("stream4_rdata", rd0, 32'hA2A3A0A1);
    issue(0, 24'h000008);
    wait_valid(0, c, hi);
    check("stream8_latency", c, 32'd65);
    check("stream8_csb_low", hi, 32'd0);
    check("stream8_rdata", rd0, 32'hAEAFACAD);
    issue(0, 24'h000010);
    wait_valid(0, c, hi);
    check("gap10_latency", c, 32'd131);
    check("gap10_csb_high", hi, 32'd2);
    check("gap10_rdata", rd0, 32'hB6B7B4B5);
    check("gap10_mosi", sh0, 32'h03000010);
    issue(0, 24'h000100);
    wait_valid(0, c, hi);
    check("gap100_latency", c, 32'd131);
    check("gap100_csb_high", hi, 32'd2);
    check("gap100_rdata", rd0, 32'hA6A7A4A5);
    check("gap100_mosi", sh0, 32'h03000100);
    c = 0;
    while (!csb0 && c < 100) begin
      tick(1);
      c++;
    end
    check("hold_expiry", c, 32'd32);
    check("gap_ready_low", 32'(req_ready), 32'd0);
    issue(0, 24'h000104);
    wait_valid(0, c, hi);
    check("after_expiry_latency", c, 32'd129);
    check("after_expiry_rdata", rd0, 32'hA2A3A0A1);
    check("after_expiry_mosi", sh0, 32'h03000104);
    issue(0, 24'hFFFFFC);
    wait_valid(0, c, hi);
    check("top_latency", c, 32'd131);
    check("top_rdata", rd0, 32'h5A5B5859);
    check("top_mosi", sh0, 32'h03FFFFFC);
    issue(0, 24'h000000);
    wait_valid(0, c, hi);
    check("wrap_latency", c, 32'd65);
    check("wrap_csb_low", hi, 32'd0);
    check("wrap_rdata", rd0, 32'h6F000093);
    check("wrap_no_cmd", sh0, 32'h03FFFFFC);
    issue(1, 24'h000000);
    tick(100);
    check("div3_in_addr", 32'(csb3), 32'd0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midrst_csb", 32'(csb3), 32'd1);
    check("midrst_clk", 32'(fclk3), 32'd0);
    check("midrst_ready", 32'(ready3), 32'd1);
    check("midrst_valid", 32'(rv3), 32'd0);
    p = 0;
    repeat (500) begin
      tick(1);
      if (rv3) p++;
    end
    check("midrst_no_valid", p, 32'd0);
    issue(1, 24'h000000);
    wait_valid(1, c, hi);
    check("div3_latency", c, 32'd385);
    check("div3_rdata", rd3, 32'h6F000093);
    check("div3_mosi", sh3, 32'h03000000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
